// File: rtl/reduce_accumulator_pkg.sv
// Shared definitions for the reduce stage: FSM state encodings and default widths.
package reduce_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_KEY_WIDTH = 4;
  localparam int unsigned DEF_VAL_WIDTH = 4;
  localparam int unsigned DEF_ACC_WIDTH = 16;

endpackage

// File: rtl/reduce_accumulator_sat_add.sv
// Saturating adder: accumulator plus a zero-extended narrow addend, with an overflow flag.
module sat_add #(
  parameter int C_ACC_WIDTH = 16,
  parameter int C_VAL_WIDTH = 4
) (
  input  logic [C_ACC_WIDTH-1:0] i_acc,
  input  logic [C_VAL_WIDTH-1:0] i_val,
  output logic [C_ACC_WIDTH-1:0] o_sum,
  output logic                   o_ovf
);

  logic [C_ACC_WIDTH:0] w_full;

  // One extra carry bit is enough to detect overflow of a single addition.
  assign w_full = {1'b0, i_acc} + {{(C_ACC_WIDTH + 1 - C_VAL_WIDTH){1'b0}}, i_val};
  assign o_ovf  = w_full[C_ACC_WIDTH];
  assign o_sum  = o_ovf ? {C_ACC_WIDTH{1'b1}} : w_full[C_ACC_WIDTH-1:0];

endmodule

// File: rtl/reduce_accumulator.sv
// Reduce stage: pops {key,value} records into a per-key saturating sum table and
// streams the non-zero entries out on a flush, clearing each one as it is accepted.
module reduce_accumulator
  import reduce_accumulator_pkg::*;
#(
  parameter int C_KEY_WIDTH = DEF_KEY_WIDTH,
  parameter int C_VAL_WIDTH = DEF_VAL_WIDTH,
  parameter int C_ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [C_KEY_WIDTH+C_VAL_WIDTH-1:0] fifo_dout,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic                           flush_req,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [C_KEY_WIDTH-1:0]         out_key,
  output logic [C_ACC_WIDTH-1:0]         out_sum,
  output logic                           flush_done,
  output logic                           busy,
  output logic                           sat_flag,
  output logic [1:0]                     dbg_state
);

  localparam int DEPTH = 1 << C_KEY_WIDTH;

  // Output handshake: a pair transfers on a cycle where out_valid and out_ready are
  // both high; once out_valid rises it stays high with key/sum stable until accepted.
  state_t                 r_state;
  logic                   r_pop_q;
  logic [C_KEY_WIDTH-1:0] r_idx;
  logic [C_ACC_WIDTH-1:0] r_acc [DEPTH];
  logic                   r_sat;

  logic [C_KEY_WIDTH-1:0] w_key;
  logic [C_VAL_WIDTH-1:0] w_val;
  logic [C_ACC_WIDTH-1:0] w_cur;
  logic [C_ACC_WIDTH-1:0] w_sum;
  logic                   w_ovf;
  logic                   w_emit;
  logic                   w_emit_adv;
  logic                   w_last;

  assign w_key = fifo_dout[C_KEY_WIDTH+C_VAL_WIDTH-1:C_VAL_WIDTH];
  assign w_val = fifo_dout[C_VAL_WIDTH-1:0];
  assign w_cur = r_acc[r_idx];

  sat_add #(
    .C_ACC_WIDTH (C_ACC_WIDTH),
    .C_VAL_WIDTH (C_VAL_WIDTH)
  ) u_sat_add (
    .i_acc (r_acc[w_key]),
    .i_val (w_val),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  assign w_emit     = (r_state == ST_EMIT);
  assign w_last     = (r_idx == {C_KEY_WIDTH{1'b1}});
  // Zero entries are skipped without a handshake, one cycle each.
  assign w_emit_adv = w_emit && ((w_cur == '0) || out_ready);

  assign fifo_rd_en = !rst && (r_state == ST_RUN) && !fifo_empty && !flush_req;
  assign out_valid  = w_emit && (w_cur != '0);
  assign out_key    = r_idx;
  assign out_sum    = w_emit ? w_cur : '0;
  assign flush_done = (r_state == ST_DONE);
  assign busy       = (r_state != ST_RUN);
  assign sat_flag   = r_sat;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pop_q <= 1'b0;
      r_idx   <= '0;
      r_sat   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_pop_q <= fifo_rd_en;
      if (r_pop_q) begin
        r_acc[w_key] <= w_sum;
        if (w_ovf) begin
          r_sat <= 1'b1;
        end
      end
      case (r_state)
        ST_RUN: begin
          if (flush_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_idx   <= '0;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_emit_adv) begin
            if (out_valid) begin
              r_acc[r_idx] <= '0;
            end
            r_idx <= r_idx + 1'b1;
            // End on the last index rather than on idx wrapping back to zero.
            if (w_last) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
